// File: rtl/abr_banked_mem.sv
// Bank-interleaved two-port scratch memory: fixed-priority A-over-B bank arbitration, byte-enabled writes,
// READ_LAT (1|2) cycle read latency, zeroize sweep; no read-data backpressure, B stalls on a bank conflict with A.
// Optional per-byte even parity storage and sticky error flag under `ABR_BANKED_MEM_PARITY_EN`.
module abr_banked_mem #(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 256,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 1,
    localparam int ADDR_W   = $clog2(NUM_BANKS * DEPTH),
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_b,
    input  logic              zeroize_i,
    output logic              zeroize_done_o,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic [BE_W-1:0]   a_be_i,
    output logic              a_ready_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    input  logic [BE_W-1:0]   b_be_i,
    output logic              b_ready_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_rdata_o
`ifdef ABR_BANKED_MEM_PARITY_EN
    ,
    output logic              parity_err_o
`endif
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BI_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = $clog2(DEPTH);
`ifdef ABR_BANKED_MEM_PARITY_EN
    localparam int MEM_W     = DATA_W + BE_W;
`else
    localparam int MEM_W     = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, ZERO, DONE} state_t;

    state_t           state, state_nxt;
    logic [ROW_W-1:0] row_cnt;
    logic             zero_we;
    logic [MEM_W-1:0] mem [NUM_BANKS][DEPTH];

    logic [1:0]        req, we, rdy, acc_rd, acc_wr;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [BE_W-1:0]   be    [2];
    logic [BI_W-1:0]   bank  [2];
    logic [ROW_W-1:0]  row   [2];

    assign req   = {b_req_i, a_req_i};
    assign we    = {b_we_i, a_we_i};
    assign rdy   = {b_ready_o, a_ready_o};
    assign addr  = '{a_addr_i, b_addr_i};
    assign wdata = '{a_wdata_i, b_wdata_i};
    assign be    = '{a_be_i, b_be_i};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            bank[p] = BI_W'(addr[p] % NUM_BANKS);
            row[p]  = ROW_W'(addr[p] / NUM_BANKS);
        end
    end

    assign acc_rd = req & rdy & ~we;
    assign acc_wr = req & rdy & we;

    always_ff @(posedge clk_i) begin
        if (!rst_b) begin
            state   <= IDLE;
            row_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ZERO) row_cnt <= row_cnt + 1'b1;
            else               row_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (zeroize_i) state_nxt = ZERO;
            ZERO:    if (row_cnt == ROW_W'(DEPTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port A never stalls in IDLE; B yields only when A targets the same bank.
    always_comb begin
        a_ready_o      = 1'b0;
        b_ready_o      = 1'b0;
        zeroize_done_o = 1'b0;
        zero_we        = 1'b0;
        if (rst_b) begin
            case (state)
                IDLE: begin
                    a_ready_o = 1'b1;
                    b_ready_o = !(a_req_i && (bank[0] == bank[1]));
                end
                ZERO:    zero_we        = 1'b1;
                DONE:    zeroize_done_o = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int bk = 0; bk < NUM_BANKS; bk++) begin
            if (zero_we) begin
                mem[bk][row_cnt] <= '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (acc_wr[p] && (bank[p] == BI_W'(bk))) begin
                        for (int i = 0; i < BE_W; i++) begin
                            if (be[p][i]) begin
                                mem[bk][row[p]][8*i +: 8] <= wdata[p][8*i +: 8];
`ifdef ABR_BANKED_MEM_PARITY_EN
                                mem[bk][row[p]][DATA_W+i] <= ^wdata[p][8*i +: 8];
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    // First read stage holds its data between reads, so rdata is stable until the next rvalid.
    logic [1:0]       v1, vo;
    logic [MEM_W-1:0] d1   [2];
    logic [MEM_W-1:0] dout [2];

    always_ff @(posedge clk_i) begin
        if (!rst_b) begin
            v1 <= '0;
            for (int p = 0; p < 2; p++) d1[p] <= '0;
        end else begin
            v1 <= acc_rd;
            for (int p = 0; p < 2; p++)
                if (acc_rd[p]) d1[p] <= mem[bank[p]][row[p]];
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [1:0]       v2;
            logic [MEM_W-1:0] d2 [2];
            always_ff @(posedge clk_i) begin
                if (!rst_b) begin
                    v2 <= '0;
                    for (int p = 0; p < 2; p++) d2[p] <= '0;
                end else begin
                    v2 <= v1;
                    for (int p = 0; p < 2; p++) d2[p] <= d1[p];
                end
            end
            assign vo   = v2;
            assign dout = d2;
        end else begin : g_lat1
            assign vo   = v1;
            assign dout = d1;
        end
    endgenerate

    assign a_rvalid_o = vo[0];
    assign b_rvalid_o = vo[1];
    assign a_rdata_o  = dout[0][DATA_W-1:0];
    assign b_rdata_o  = dout[1][DATA_W-1:0];

`ifdef ABR_BANKED_MEM_PARITY_EN
    function automatic logic [BE_W-1:0] par_of(input logic [DATA_W-1:0] d);
        logic [BE_W-1:0] r;
        r = '0;
        for (int i = 0; i < BE_W; i++) r[i] = ^d[8*i +: 8];
        return r;
    endfunction

    logic par_err;
    always_ff @(posedge clk_i) begin
        if (!rst_b) begin
            par_err <= 1'b0;
        end else if (state == IDLE && zeroize_i) begin
            par_err <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (vo[p] && (dout[p][MEM_W-1:DATA_W] != par_of(dout[p][DATA_W-1:0])))
                    par_err <= 1'b1;
        end
    end
    assign parity_err_o = par_err;
`endif
endmodule
